// File: rtl/cla_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_sched_pkg
// Purpose  : Shared constants and types for the shared-adder scheduler:
//            FSM state encoding, default operand/slice widths, id width.
// Revision : 1.0 - initial release
// ============================================================================
package cla_sched_pkg;

  // Default operand width and adder slice width
  localparam int C_DEF_WIDTH = 32;
  localparam int C_DEF_SLICE = 16;

  // Width of the requester id carried with each operation
  localparam int C_ID_W      = 1;

  // Width of one first-level lookahead block inside the slice adder
  localparam int C_BLK_W     = 4;

  // Scheduler FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : cla_sched_pkg
`default_nettype wire

// File: rtl/cla_slice16.sv
`default_nettype none
// ============================================================================
// Module   : cla_slice16
// Purpose  : SLICE-bit combinational carry-lookahead adder. Built from 4-bit
//            lookahead blocks (local generate/propagate) and a second-level
//            lookahead unit producing every block carry-in directly from the
//            block group generate/propagate terms and the slice carry-in.
//            SLICE must be a multiple of 4.
// Revision : 1.0 - initial release
// ============================================================================
module cla_slice16
  import cla_sched_pkg::*;
#(
  parameter int SLICE = C_DEF_SLICE
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout
);

  localparam int NBLK = SLICE / C_BLK_W;

  logic [NBLK-1:0] w_bg;   // block group generate
  logic [NBLK-1:0] w_bp;   // block group propagate
  logic [NBLK:0]   w_bc;   // carry into each block; top bit is slice carry-out
  logic            w_acc;
  logic            w_term;

  // First level: 4-bit lookahead blocks
  generate
    for (genvar j = 0; j < NBLK; j++) begin : g_blk
      logic [3:0] w_g;
      logic [3:0] w_p;
      logic [3:0] w_c;

      assign w_g = i_a[j*C_BLK_W +: C_BLK_W] & i_b[j*C_BLK_W +: C_BLK_W];
      assign w_p = i_a[j*C_BLK_W +: C_BLK_W] ^ i_b[j*C_BLK_W +: C_BLK_W];

      assign w_c[0] = w_bc[j];
      assign w_c[1] = w_g[0] | (w_p[0] & w_bc[j]);
      assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_bc[j]);
      assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                    | (w_p[2] & w_p[1] & w_p[0] & w_bc[j]);

      assign w_bg[j] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                     | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
      assign w_bp[j] = &w_p;

      assign o_sum[j*C_BLK_W +: C_BLK_W] = w_p ^ w_c;
    end
  endgenerate

  // Second level: flattened lookahead, each block carry as a sum of products
  always_comb begin
    w_bc   = '0;
    w_acc  = 1'b0;
    w_term = 1'b0;
    w_bc[0] = i_cin;
    for (int j = 1; j <= NBLK; j++) begin
      // carry-in propagated through every lower block
      w_acc = i_cin;
      for (int m = 0; m < j; m++) begin
        w_acc = w_acc & w_bp[m];
      end
      // generate in block m propagated through blocks m+1..j-1
      for (int m = 0; m < j; m++) begin
        w_term = w_bg[m];
        for (int n = m + 1; n < j; n++) begin
          w_term = w_term & w_bp[n];
        end
        w_acc = w_acc | w_term;
      end
      w_bc[j] = w_acc;
    end
  end

  assign o_cout = w_bc[NBLK];

endmodule : cla_slice16
`default_nettype wire

// File: rtl/cla_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : cla_add_sched
// Purpose  : Two-requester round-robin scheduler for one shared SLICE-bit
//            lookahead adder. A WIDTH-bit add is sequenced over WIDTH/SLICE
//            cycles with the inter-slice carry held in a register; the result
//            returns with carry-out, signed overflow and requester id.
// Options  : ADDSCHED_SUB_EN - adds reqN_sub ports; sub=1 computes a - b as
//            a + ~b + 1 (cout = 1 means no borrow).
// Revision : 1.0 - initial release
// ============================================================================
module cla_add_sched
  import cla_sched_pkg::*;
#(
  parameter int WIDTH = C_DEF_WIDTH,
  parameter int SLICE = C_DEF_SLICE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic              req0_cin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic              req1_cin,
`ifdef ADDSCHED_SUB_EN
  input  logic              req0_sub,
  input  logic              req1_sub,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ofl,
  output logic [C_ID_W-1:0] rsp_id,
  output logic              busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e              r_state;
  state_e              w_next;
  logic [KW-1:0]       r_k;
  logic                r_carry;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_sum;
  logic [C_ID_W-1:0]   r_id;
  logic [C_ID_W-1:0]   r_last;
  logic                r_cout;
  logic                r_ofl;

  logic                w_grant0;
  logic                w_grant1;
  logic                w_hs;
  logic                w_last_slice;
  logic [WIDTH-1:0]    w_sel_a;
  logic [WIDTH-1:0]    w_sel_b;
  logic                w_sel_cin;
  logic [WIDTH-1:0]    w_b_eff;
  logic                w_cin_eff;
  logic [31:0]         w_base;
  logic [SLICE-1:0]    w_slice_a;
  logic [SLICE-1:0]    w_slice_b;
  logic [SLICE-1:0]    w_slice_sum;
  logic                w_slice_cout;

  // Round-robin grant: a tie goes to the requester not served last
  assign w_grant0 = req0_valid & (~req1_valid | (r_last == C_ID_W'(1)));
  assign w_grant1 = req1_valid & (~req0_valid | (r_last == C_ID_W'(0)));
  assign w_hs     = (r_state == IDLE) & ~rst & (w_grant0 | w_grant1);

  // Operand mux for the granted requester
  always_comb begin
    w_sel_a   = req0_a;
    w_sel_b   = req0_b;
    w_sel_cin = req0_cin;
    if (w_grant1) begin
      w_sel_a   = req1_a;
      w_sel_b   = req1_b;
      w_sel_cin = req1_cin;
    end
  end

`ifdef ADDSCHED_SUB_EN
  logic w_sel_sub;
  assign w_sel_sub = w_grant1 ? req1_sub : req0_sub;
  assign w_b_eff   = w_sel_sub ? ~w_sel_b : w_sel_b;
  assign w_cin_eff = w_sel_sub | w_sel_cin;
`else
  assign w_b_eff   = w_sel_b;
  assign w_cin_eff = w_sel_cin;
`endif

  // Current slice of the latched operands feeds the single shared adder
  assign w_base       = 32'(r_k) * 32'(SLICE);
  assign w_slice_a    = r_a[w_base +: SLICE];
  assign w_slice_b    = r_b[w_base +: SLICE];
  assign w_last_slice = (r_k == KW'(NSLICE - 1));

  cla_slice16 #(
    .SLICE (SLICE)
  ) u_slice (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM next state and request-ready decode; ready is held low during reset
  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = w_grant0 & ~rst;
        req1_ready = w_grant1 & ~rst;
        if (w_hs) w_next = CALC;
      end
      CALC: if (w_last_slice) w_next = DONE;
      DONE: if (rsp_ready)    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latch operands, step one slice per cycle, record the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_id    <= '0;
      r_last  <= C_ID_W'(1);
      r_cout  <= 1'b0;
      r_ofl   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_a     <= w_sel_a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_id    <= w_grant1 ? C_ID_W'(1) : C_ID_W'(0);
            r_k     <= '0;
            r_sum   <= '0;
          end
        end
        CALC: begin
          r_sum[w_base +: SLICE] <= w_slice_sum;
          r_carry                <= w_slice_cout;
          r_k                    <= r_k + KW'(1);
          if (w_last_slice) begin
            r_cout <= w_slice_cout;
            r_ofl  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &
                      (w_slice_sum[SLICE-1] != r_a[WIDTH-1]);
          end
        end
        DONE: begin
          if (rsp_ready) r_last <= r_id;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == DONE);
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_ofl   = r_ofl;
  assign rsp_id    = r_id;
  assign busy      = (r_state != IDLE);

endmodule : cla_add_sched
`default_nettype wire

// File: tb/tb_cla_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_add_sched
// Purpose  : Self-checking bench for cla_add_sched: constant vector table,
//            hand-written contention / backpressure / mid-operation reset
//            sequences and randomized traffic against an arithmetic model.
// Options  : ADDSCHED_SUB_EN - drives the subtract ports and checks 5 - 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_add_sched;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 16;
  localparam int NSLICE = WIDTH / SLICE;
`ifdef ADDSCHED_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ofl;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ofl;
  } res_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [WIDTH-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic              req0_cin = 1'b0, req1_cin = 1'b0;
  logic              req0_sub = 1'b0, req1_sub = 1'b0;
  logic              rsp_valid, rsp_ready = 1'b0;
  logic [WIDTH-1:0]  rsp_sum;
  logic              rsp_cout, rsp_ofl;
  logic [0:0]        rsp_id;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int m_last   = 1;   // model of the requester served last

  always #5 clk = ~clk;

  cla_add_sched #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
`ifdef ADDSCHED_SUB_EN
    .req0_sub   (req0_sub),
    .req1_sub   (req1_sub),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ofl    (rsp_ofl),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  // Reference: plain 33-bit arithmetic on the effective operands
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    res_t        r;
    logic [31:0] be;
    logic        ce;
    logic [32:0] full;
    be   = (SUB_EN && sub) ? ~b : b;
    ce   = (SUB_EN && sub) ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, be} + 33'(ce);
    r.sum  = full[31:0];
    r.cout = full[32];
    r.ofl  = (a[31] == be[31]) && (full[31] != a[31]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // One operation: present requests, check grant, latency, hold stability
  // under backpressure and the result against the model.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic c0, input logic s0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic c1, input logic s1,
                        input int hold, output int gid,
                        output logic [31:0] o_sum, output logic o_cout,
                        output logic o_ofl);
    int          n;
    int          eg;
    res_t        e;
    logic [31:0] cap_sum;
    logic        cap_cout, cap_ofl, cap_id;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1; req1_sub = s1;
    o_sum = '0; o_cout = 1'b0; o_ofl = 1'b0;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!(req0_ready || req1_ready)) begin
      chk("grant_timeout", 64'd0, 64'd1);
      gid = -1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    chk("one_ready", 64'(req0_ready & req1_ready), 64'd0);
    gid = req1_ready ? 1 : 0;
    eg  = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
    chk("grant", 64'(gid), 64'(eg));
    e = (gid == 1) ? model(a1, b1, c1, s1) : model(a0, b0, c0, s0);
    @(posedge clk); #1;
    n = 1;
    while (!rsp_valid && n < 20) begin
      chk("ready_low_busy", 64'(req0_ready | req1_ready), 64'd0);
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'(NSLICE + 1));
    cap_sum = rsp_sum; cap_cout = rsp_cout; cap_ofl = rsp_ofl; cap_id = rsp_id;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_stable", {31'd0, rsp_sum, rsp_cout, rsp_ofl},
          {31'd0, cap_sum, cap_cout, cap_ofl});
      chk("hold_ready_low", 64'(req0_ready | req1_ready), 64'd0);
    end
    chk("sum",  64'(rsp_sum),  64'(e.sum));
    chk("cout", 64'(rsp_cout), 64'(e.cout));
    chk("ofl",  64'(rsp_ofl),  64'(e.ofl));
    chk("id",   64'(rsp_id),   64'(gid));
    o_sum = rsp_sum; o_cout = rsp_cout; o_ofl = rsp_ofl;
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_after_rsp", 64'({busy, rsp_valid}), 64'd0);
    m_last = gid;
  endtask

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    int          gid;
    int          n;
    int          prev;
    logic [31:0] s;
    logic        co, of;
    logic [1:0]  pat;
    res_t        e;

    vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'h00000000, 1'b1, 1'b0};

    // ---- reset with both requesters valid
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
    chk("rst_outs", {31'd0, rsp_valid, busy, rsp_cout, rsp_ofl, rsp_id, rsp_sum},
        64'd0);
    rst = 1'b0;
    #1;
    chk("tiebreak_after_rst", 64'({req0_ready, req1_ready}), 64'b10);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // ---- constant vector table, alternating requester ports
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        run_op(1'b1, 1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
               32'h0, 32'h0, 1'b0, 1'b0, (i == 1) ? 5 : i % 3, gid, s, co, of);
      else
        run_op(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0,
               vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
               (i == 1) ? 5 : i % 3, gid, s, co, of);
      chk($sformatf("vec%0d_sum", i),  64'(s),  64'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].cout));
      chk($sformatf("vec%0d_ofl", i),  64'(of), 64'(vecs[i].ofl));
      chk($sformatf("vec%0d_id", i),   64'(gid), 64'(i % 2));
    end

    // ---- contention: both valid continuously, consumer always ready
    req0_a = 32'h00000100; req0_b = 32'h00000023; req0_cin = 1'b0; req0_sub = 1'b0;
    req1_a = 32'hFFFFFFF0; req1_b = 32'h00000020; req1_cin = 1'b1; req1_sub = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    prev = m_last;
    #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(posedge clk); #1; n++;
      end
      chk("cont_grant_seen", 64'(req0_ready | req1_ready), 64'd1);
      gid = req1_ready ? 1 : 0;
      chk("cont_alternate", 64'(gid), 64'((prev == 1) ? 0 : 1));
      prev = gid;
      e = (gid == 1) ? model(req1_a, req1_b, req1_cin, 1'b0)
                     : model(req0_a, req0_b, req0_cin, 1'b0);
      @(posedge clk); #1;
      n = 1;
      while (!rsp_valid && n < 20) begin
        @(posedge clk); #1; n++;
      end
      chk("cont_latency", 64'(n), 64'(NSLICE + 1));
      chk("cont_no_accept_in_rsp", 64'(req0_ready | req1_ready), 64'd0);
      chk("cont_sum", {31'd0, rsp_sum, rsp_cout, rsp_id}, {31'd0, e.sum, e.cout, 1'(gid)});
      m_last = gid;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;

    // ---- reset during CALC discards the operation
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h2; req0_cin = 1'b0;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("midcalc_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midcalc_rst_outs", {30'd0, rsp_valid, busy, rsp_cout, rsp_ofl, rsp_id, rsp_sum},
        64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 1;
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) n++;
    end
    chk("midcalc_no_rsp", 64'(n), 64'd0);

    // next request after reset; tie goes to requester 0
    run_op(1'b1, 1'b1, 32'd5, 32'd3, 1'b0, 1'b1, 32'd9, 32'd9, 1'b0, 1'b0,
           2, gid, s, co, of);
`ifdef ADDSCHED_SUB_EN
    chk("sub_5m3_sum",  64'(s),  64'd2);
    chk("sub_5m3_cout", 64'(co), 64'd1);
`else
    chk("post_rst_sum",  64'(s),  64'd8);
    chk("post_rst_cout", 64'(co), 64'd0);
`endif
    chk("post_rst_id", 64'(gid), 64'd0);

    // ---- randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      pat = 2'($urandom_range(1, 3));
      run_op(pat[0], pat[1],
             $urandom, $urandom, 1'($urandom), 1'($urandom),
             $urandom, $urandom, 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), gid, s, co, of);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cla_add_sched
`default_nettype wire

// File: doc/cla_add_sched.md
# cla_add_sched

Two-requester scheduler for a shared slice-wide carry-lookahead adder. It accepts WIDTH-bit add requests over valid/ready, arbitrates round-robin, and sequences the operation through one SLICE-bit lookahead adder over WIDTH/SLICE cycles, holding the inter-slice carry in a register. It returns sum, carry-out and signed overflow tagged with the requester id. It sits between the ALU/address-generation clients and the single lookahead adder instance they share.

## Interface
- WIDTH, 32, operand width; must be a multiple of SLICE.
- SLICE, 16, adder slice width; NSLICE = WIDTH/SLICE ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_cin / req1_cin  in  1  carry-in.
- req0_sub / req1_sub  in  1  subtract; present only with ADDSCHED_SUB_EN.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  WIDTH  result.
- rsp_cout  out  1  carry out of the MSB.
- rsp_ofl  out  1  signed overflow.
- rsp_id  out  1  requester served (0/1).
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Grant is combinational. A single valid requester is granted. If both are valid, grant the requester not served last. The pointer resets to "last = 1", so requester 0 wins the first tie.
  - reqN_ready = (state==IDLE) & grantN; at most one ready is high.
  - On handshake: latch a, b_eff, cin_eff and id; clear slice index k and sum register; go to CALC.
- CALC: each cycle, slice k computes sum[k*SLICE +: SLICE] = a_slice + b_slice + carry_reg.
  - Write the slice into the sum register; carry_reg ← slice carry-out; k++.
  - After slice NSLICE-1, go to DONE and latch cout and ofl.
- Overflow: ofl = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]).
- DONE: rsp_valid=1, with rsp_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready: update the round-robin pointer to rsp_id; go to IDLE.
- Both reqN_ready are low outside IDLE; a requester's valid may stay high across the wait.
- Reset, including mid-CALC or DONE: state IDLE, k=0, carry_reg=0, sum register 0, pointer = 1. The in-flight operation is discarded and not reported.
- Output reset values: rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_ofl 0, rsp_id 0, busy 0, ready outputs 0 until a valid arrives.

## Timing
- Handshake in cycle T: CALC runs cycles T+1..T+NSLICE, and rsp_valid rises in cycle T+NSLICE+1. Default: T+3.
- Minimum issue interval is NSLICE+2 cycles (DONE then IDLE); no overlap of operations.
- Response and new-request acceptance are never in the same cycle.
- All outputs are registered or decoded from registered state, except reqN_ready, which is combinational from the valid inputs in IDLE.

## Configuration
- ADDSCHED_SUB_EN defined:
  - reqN_sub ports exist.
  - sub=1 latches b_eff = ~b and cin_eff = 1, ignoring cin.
  - cout is the raw adder carry (1 = no borrow); ofl uses b_eff.
- ADDSCHED_SUB_EN undefined: reqN_sub ports are absent; b_eff = b and cin_eff = cin.

## Structure
- Shared package `cla_sched_pkg` holds:
  - FSM state encoding constants (IDLE, CALC, DONE).
  - WIDTH and SLICE defaults.
  - Requester id width.
- Sub-module `cla_slice16`: SLICE-bit combinational adder built from 4-bit lookahead blocks plus a second-level lookahead unit. The scheduler instantiates exactly one.

## Test plan
- Reset: hold rst with both valids high → both ready 0, rsp_valid 0, busy 0. Release → req0_ready=1 first (tie-break).
- Slice carry: req0 a=0x0000FFFF, b=0x00000001, cin=0 at T → rsp_valid at T+3 with sum=0x00010000, cout=0, ofl=0, id=0.
- Overflow and carry:
  - a=0x7FFFFFFF, b=1 → sum=0x80000000, ofl=1, cout=0.
  - a=0xFFFFFFFF, b=1 → sum=0, cout=1, ofl=0.
- Contention: both valids high continuously, rsp_ready=1 → grants alternate 0,1,0,1 over four operations. Each result matches its requester's operands.
- Backpressure: rsp_ready low for 5 cycles in DONE → rsp_* stable, both ready low. Raise rsp_ready → IDLE the next cycle, then the next grant.
- Reset mid-CALC: assert rst in cycle T+1 → outputs zero immediately, no response emitted. The next request completes correctly. With ADDSCHED_SUB_EN: 5−3 → sum=2, cout=1.
